// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and SRAM controller state encoding.
// Imported by the SRAM controller and the byte merge helper.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_FREE
   } state_t;

endpackage

// File: rtl/ahb_byte_merge.sv
// Little-endian lane merge of a new word into an old word.
// Sizes above halfword replace the whole word.
module ahb_byte_merge
   import ahb_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   // Replace only the lanes selected by size and low address bits
   always_comb begin
      merged = old_word;
      case (size)
         HSIZE_BYTE:
            merged[{offset, 3'b000} +: 8] =
               new_word[{offset, 3'b000} +: 8];
         HSIZE_HALF:
            merged[{offset[1], 4'b0000} +: 16] =
               new_word[{offset[1], 4'b0000} +: 16];
         default:
            merged = new_word;
      endcase
   end

endmodule

// File: rtl/ahb_sram_2k_ctrl.sv
// AHB-Lite slave for a single-port 512x32 SRAM.
// Zero-wait reads, word writes, read-modify-write for sub-words.
module ahb_sram_2k_ctrl
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  hsel,
   input  logic [31:0]           haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [31:0]           hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic [31:0]           hrdata,
   output logic                  hresp,
   output logic                  sram_cs,
   output logic                  sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_data,
   input  logic [31:0]           sram_q
);

   state_t                state_q, state_d;
   logic                  rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            off_q, off_d;
   logic [2:0]            size_q, size_d;

   logic        accept;
   logic        rd_req;
   logic        wr_phase;
   logic [31:0] merged;
   logic        unused_ok;

   assign accept   = hsel & htrans[1] & hready;
   assign rd_req   = hsel & htrans[1] & ~hwrite;
   assign wr_phase = (state_q == ST_WR) | (state_q == ST_RMW_WR);
   assign hresp    = HRESP_OKAY;
   assign hrdata   = rd_q ? sram_q : 32'h0;
   assign unused_ok = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

   ahb_byte_merge u_merge (
      .old_word (sram_q),
      .new_word (hwdata),
      .size     (size_q),
      .offset   (off_q),
      .merged   (merged)
   );

   // Stall only on the RMW read or a read colliding with a write
   always_comb begin
      hreadyout = 1'b1;
      if (state_q == ST_RMW_RD) begin
         hreadyout = 1'b0;
      end else if (wr_phase && rd_req) begin
         hreadyout = 1'b0;
      end
   end

   // Next state, latched address phase and SRAM port drive
   always_comb begin
      state_d   = ST_IDLE;
      rd_d      = 1'b0;
      addr_d    = addr_q;
      off_d     = off_q;
      size_d    = size_q;
      sram_cs   = 1'b0;
      sram_wen  = 1'b1;
      sram_addr = addr_q;
      sram_data = 32'h0;
      case (state_q)
         ST_WR: begin
            sram_cs   = 1'b1;
            sram_wen  = 1'b0;
            sram_data = hwdata;
         end
         ST_RMW_RD: begin
            sram_cs = 1'b1;
         end
         ST_RMW_WR: begin
            sram_cs   = 1'b1;
            sram_wen  = 1'b0;
            sram_data = merged;
         end
         default: ;
      endcase
      if (state_q == ST_RMW_RD) begin
         state_d = ST_RMW_WR;
      end else if (wr_phase && rd_req) begin
         state_d = ST_FREE;
      end else if (accept) begin
         addr_d = haddr[ADDR_WIDTH+1:2];
         off_d  = haddr[1:0];
         size_d = hsize;
         if (hwrite) begin
            if (hsize == HSIZE_BYTE || hsize == HSIZE_HALF) begin
               state_d = ST_RMW_RD;
            end else begin
               state_d = ST_WR;
            end
         end else begin
            rd_d      = 1'b1;
            sram_cs   = 1'b1;
            sram_addr = haddr[ADDR_WIDTH+1:2];
         end
      end
   end

   // State and data-phase registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         off_q   <= 2'b00;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         size_q  <= size_d;
      end
   end

endmodule

// File: tb/tb_ahb_sram_2k_ctrl.sv
// Bench for ahb_sram_2k_ctrl: pipelined AHB master, SRAM model,
// word-array reference memory with byte-lane write rules.
module tb_ahb_sram_2k_ctrl;
   import ahb_pkg::*;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rstn;
   logic          hsel;
   logic [31:0]   haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [31:0]   hwdata;
   logic          hready;
   logic          hreadyout;
   logic [31:0]   hrdata;
   logic          hresp;
   logic          sram_cs;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_data;
   logic [31:0]   sram_q;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      logic        hx;
      logic [31:0] ex;
   } item_t;

   item_t       seq[$];
   logic [31:0] ref_mem [512];
   logic [31:0] sram_mem [512];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   assign hready = hreadyout;

   ahb_sram_2k_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
      .hrdata(hrdata), .hresp(hresp), .sram_cs(sram_cs),
      .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_data(sram_data), .sram_q(sram_q)
   );

   // SRAM macro model: 1-cycle read latency, q held otherwise
   initial begin
      for (int k = 0; k < 512; k++) sram_mem[k] = 32'h0;
      forever begin
         @(posedge clk);
         if (sram_cs) begin
            if (!sram_wen) sram_mem[sram_addr] = sram_data;
            else sram_q <= sram_mem[sram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit active(input item_t t);
      return t.sel && t.trans[1];
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[AW+1:2]);
   endfunction

   task automatic apply_wr(input item_t t);
      int sz;
      int off;
      bit take;
      sz  = (t.size > 3'd2) ? 2 : int'(t.size);
      off = int'(t.addr[1:0]);
      for (int l = 0; l < 4; l++) begin
         take = (sz == 2) || (sz == 1 && l / 2 == off / 2) ||
                (sz == 0 && l == off);
         if (take) ref_mem[widx(t.addr)][8*l +: 8] = t.data[8*l +: 8];
      end
   endtask

   task automatic push_w(input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d);
      item_t t;
      t = '{1'b1, HTRANS_NONSEQ, 1'b1, s, a, d, 1'b0, 32'h0};
      seq.push_back(t);
   endtask

   task automatic push_r(input logic [31:0] a, input bit hx,
                         input logic [31:0] ex);
      item_t t;
      t = '{1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, 32'h0, hx, ex};
      seq.push_back(t);
   endtask

   task automatic push_i(input logic sel, input logic [1:0] tr);
      item_t t;
      t = '{sel, tr, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b0, 32'h0};
      seq.push_back(t);
   endtask

   task automatic drive_idle();
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      haddr  = 32'h0;
      hwrite = 1'b0;
      hsize  = 3'd0;
   endtask

   // Waits predicted from the transfer order alone
   function automatic int exp_waits();
      int w = 0;
      for (int k = 0; k < seq.size(); k++) begin
         if (active(seq[k]) && seq[k].wr && seq[k].size < 3'd2) w++;
         if (active(seq[k]) && !seq[k].wr && k > 0)
            if (active(seq[k-1]) && seq[k-1].wr) w++;
      end
      return w;
   endfunction

   task automatic run_seq(input string tag, input int exp_st);
      int   i = 0;
      int   dp = -1;
      int   st = 0;
      int   cyc = 0;
      logic rdy;
      logic [31:0] ev;
      while (i < seq.size() || dp >= 0) begin
         @(posedge clk);
         #1;
         if (i < seq.size()) begin
            hsel   = seq[i].sel;
            htrans = seq[i].trans;
            haddr  = seq[i].addr;
            hwrite = seq[i].wr;
            hsize  = seq[i].size;
         end else begin
            drive_idle();
         end
         hwdata = (dp >= 0 && seq[dp].wr) ? seq[dp].data : 32'h0;
         @(negedge clk);
         rdy = hreadyout;
         chk({tag, "_hresp"}, {31'h0, hresp}, 32'h0);
         if (!rdy) st++;
         if (rdy) begin
            if (dp >= 0 && !seq[dp].wr) begin
               ev = seq[dp].hx ? seq[dp].ex : ref_mem[widx(seq[dp].addr)];
               chk({tag, "_hrdata"}, hrdata, ev);
            end
            if (dp >= 0 && seq[dp].wr) apply_wr(seq[dp]);
            if (i < seq.size() && active(seq[i])) begin
               if (!seq[i].wr) begin
                  chk({tag, "_rd_cs"}, {31'h0, sram_cs}, 32'h1);
                  chk({tag, "_rd_wen"}, {31'h0, sram_wen}, 32'h1);
                  chk({tag, "_rd_addr"}, 32'(sram_addr),
                      32'(widx(seq[i].addr)));
               end
            end else if (dp < 0 || !seq[dp].wr) begin
               chk({tag, "_idle_cs"}, {31'h0, sram_cs}, 32'h0);
            end
            if (i < seq.size() && active(seq[i])) dp = i;
            else dp = -1;
            if (i < seq.size()) i++;
         end
         cyc++;
         if (cyc > 3000) begin
            chk({tag, "_timeout"}, 32'(cyc), 32'h0);
            break;
         end
      end
      chk({tag, "_waits"}, 32'(st), 32'(exp_st));
      seq.delete();
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_hreadyout"}, {31'h0, hreadyout}, 32'h1);
      chk({tag, "_hresp"}, {31'h0, hresp}, 32'h0);
      chk({tag, "_hrdata"}, hrdata, 32'h0);
      chk({tag, "_cs"}, {31'h0, sram_cs}, 32'h0);
      chk({tag, "_wen"}, {31'h0, sram_wen}, 32'h1);
      chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
      chk({tag, "_data"}, sram_data, 32'h0);
   endtask

   initial begin
      for (int k = 0; k < 512; k++) ref_mem[k] = 32'h0;
      rstn = 1'b0;
      drive_idle();
      hwdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("reset");
      @(posedge clk);
      #1 rstn = 1'b1;

      push_w(32'h10, HSIZE_WORD, 32'hDEADBEEF);
      push_r(32'h10, 1'b1, 32'hDEADBEEF);
      run_seq("t1", 1);

      push_w(32'h20, HSIZE_WORD, 32'h11223344);
      push_w(32'h21, HSIZE_BYTE, 32'hAAAAAAAA);
      push_r(32'h20, 1'b1, 32'h1122AA44);
      run_seq("t2", 2);

      push_w(32'h20, HSIZE_WORD, 32'h11223344);
      push_i(1'b0, HTRANS_IDLE);
      push_w(32'h22, HSIZE_HALF, 32'hBEEFBEEF);
      push_w(32'h24, HSIZE_WORD, 32'h01020304);
      push_w(32'h28, HSIZE_WORD, 32'h05060708);
      push_r(32'h20, 1'b1, 32'hBEEF3344);
      push_r(32'h24, 1'b1, 32'h01020304);
      push_r(32'h28, 1'b1, 32'h05060708);
      run_seq("t3", 2);

      push_w(32'h0, HSIZE_WORD, 32'hCAFEF00D);
      push_r(32'h800, 1'b1, 32'hCAFEF00D);
      run_seq("t4", 1);

      push_w(32'h40, HSIZE_WORD, 32'h55667788);
      run_seq("t5pre", 0);
      @(posedge clk);
      #1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h41;
      hwrite = 1'b1; hsize = HSIZE_BYTE;
      @(posedge clk);
      #1;
      drive_idle();
      hwdata = 32'h99999999;
      chk("t5_rmw_rd_cs", {31'h0, sram_cs}, 32'h1);
      chk("t5_rmw_rd_rdy", {31'h0, hreadyout}, 32'h0);
      rstn = 1'b0;
      #1;
      chk_reset_outs("t5_rst");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      hwdata = 32'h0;
      push_r(32'h40, 1'b1, 32'h55667788);
      push_w(32'h42, HSIZE_BYTE, 32'hABABABAB);
      push_r(32'h40, 1'b1, 32'h55AB7788);
      run_seq("t5post", 2);

      push_r(32'h10, 1'b1, 32'hDEADBEEF);
      push_i(1'b1, HTRANS_IDLE);
      push_r(32'h20, 1'b1, 32'hBEEF3344);
      push_i(1'b0, HTRANS_NONSEQ);
      push_i(1'b1, HTRANS_BUSY);
      push_r(32'h0, 1'b1, 32'hCAFEF00D);
      push_i(1'b0, HTRANS_SEQ);
      run_seq("t6", 0);

      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 50; k++) begin
            item_t t;
            if ($urandom_range(0, 9) < 2) begin
               t.sel   = 1'($urandom_range(0, 1));
               t.trans = t.sel ? 2'($urandom_range(0, 1)) : HTRANS_NONSEQ;
               t.wr    = 1'($urandom_range(0, 1));
            end else begin
               t.sel   = 1'b1;
               t.trans = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
               t.wr    = 1'($urandom_range(0, 1));
            end
            t.size = 3'($urandom_range(0, 3));
            t.addr = ($urandom & 32'hFFFFF800) |
                     32'($urandom_range(0, 15) << 2) |
                     32'($urandom_range(0, 3));
            t.data = $urandom;
            t.hx   = 1'b0;
            t.ex   = 32'h0;
            seq.push_back(t);
         end
         run_seq("rand", exp_waits());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
